// File: rtl/ccff_chain_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
// Holds the loader state encoding and the width helpers for its counters
// and the word-buffer bit index.
package ccff_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_ld_state_t;

    // Bit / mismatch counter width: must be able to hold CHAIN_LEN itself.
    function automatic int unsigned ccff_cnt_w(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Bit index width inside one bitstream word (at least 1 bit).
    function automatic int unsigned ccff_idx_w(input int unsigned word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the chain loader: holds one bitstream word and walks a bit
// index from 0 up to WORD_W-1, presenting the indexed bit.
// Ports:
//   prog_clk, pReset : clock, synchronous active-high reset
//   i_clear          : clear the bit index (new pass)
//   i_load, i_data   : load a new word, bit index restarts at 0
//   i_advance        : a bit was shifted this cycle; step the index
//   o_bit            : buffer[bit index]
//   o_last           : bit index points at the word's last bit
module ccff_word_serializer
    import ccff_chain_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
)(
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_advance,
    output logic              o_bit,
    output logic              o_last
);

    localparam int unsigned IDX_W = ccff_idx_w(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;

    // The index parks on the last bit so the presented bit holds while the
    // loader waits for the next word.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_buf <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_buf <= i_data;
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_advance && !o_last) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_last = (r_idx == LAST_IDX);
    assign o_bit  = r_buf[r_idx];

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: accepts bitstream words on a valid/ready stream
// and shifts exactly CHAIN_LEN bits into the chain head, one per cycle of
// chain_shift_en. A verify pass counts bits where the chain tail disagrees
// with the bit being presented at the head.
// Ports:
//   prog_clk, pReset          : clock, synchronous active-high reset
//   start, verify             : begin a pass (verify selects compare mode)
//   bs_data/bs_valid/bs_ready : bitstream word stream, bit 0 shifted first
//   ccff_head, chain_shift_en : serial bit and shift enable into the chain
//   ccff_tail                 : serial bit returning from the chain
//   busy, done                : pass in progress / last pass completed
//   mismatch_cnt, verify_ok   : verify result of the last pass
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = ccff_cnt_w(CHAIN_LEN)
)(
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              verify_ok
);

    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    ccff_ld_state_t r_state;
    ccff_ld_state_t w_next;

    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_mismatch;
    logic             r_verify;

    logic w_bit;
    logic w_last;
    logic w_final;
    logic w_start_ok;
    logic w_load;
    logic w_shift;

    // Bit counter holds the number of bits already shifted before this cycle.
    assign w_final    = (r_bit_cnt == FINAL_CNT);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_shift    = (r_state == SHIFT);
    assign w_load     = bs_ready && bs_valid;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .i_clear   (w_start_ok),
        .i_load    (w_load),
        .i_data    (bs_data),
        .i_advance (w_shift),
        .o_bit     (w_bit),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_next = FETCH;
            end
            FETCH: begin
                if (bs_valid) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_final) begin
                    w_next = DONE;
                end else if (w_last && !bs_valid) begin
                    w_next = FETCH;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state and registered datapath only.
    always_comb begin
        bs_ready       = 1'b0;
        chain_shift_en = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (r_state)
            FETCH: begin
                bs_ready = 1'b1;
                busy     = 1'b1;
            end
            SHIFT: begin
                busy           = 1'b1;
                chain_shift_en = 1'b1;
                // Prefetch the next word while the last buffered bit goes out.
                bs_ready       = w_last && !w_final;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        verify_ok = done && r_verify && (r_mismatch == '0);
    end

    // Bit counter, pass mode and verify mismatch counter.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_bit_cnt  <= '0;
            r_mismatch <= '0;
            r_verify   <= 1'b0;
        end else if (w_start_ok) begin
            r_bit_cnt  <= '0;
            r_mismatch <= '0;
            r_verify   <= verify;
        end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_verify && (ccff_tail != w_bit) && (r_mismatch != CNT_MAX)) begin
                r_mismatch <= r_mismatch + CNT_W'(1);
            end
        end
    end

    assign ccff_head    = w_bit;
    assign mismatch_cnt = r_mismatch;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader with a 10-bit chain and 4-bit
// words (so the third word is only half used).
module tb_ccff_chain_loader;

    localparam int L     = 10;
    localparam int W     = 4;
    localparam int NWORD = (L + W - 1) / W;

    logic         prog_clk = 1'b0;
    logic         pReset   = 1'b1;
    logic         start    = 1'b0;
    logic         verify   = 1'b0;
    logic [W-1:0] bs_data  = '0;
    logic         bs_valid = 1'b0;
    logic         bs_ready;
    logic         ccff_head;
    logic         chain_shift_en;
    logic         ccff_tail;
    logic         busy;
    logic         done;
    logic [3:0]   mismatch_cnt;
    logic         verify_ok;

    ccff_chain_loader #(
        .CHAIN_LEN (L),
        .WORD_W    (W)
    ) dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start),
        .verify         (verify),
        .bs_data        (bs_data),
        .bs_valid       (bs_valid),
        .bs_ready       (bs_ready),
        .ccff_head      (ccff_head),
        .chain_shift_en (chain_shift_en),
        .ccff_tail      (ccff_tail),
        .busy           (busy),
        .done           (done),
        .mismatch_cnt   (mismatch_cnt),
        .verify_ok      (verify_ok)
    );

    always #5 prog_clk = ~prog_clk;

    // Environment: the configuration chain itself, advancing on shift enable.
    logic [L-1:0] chain = '0;
    always @(posedge prog_clk) begin
        if (chain_shift_en) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = chain[L-1];

    int checks = 0;
    int errors = 0;

    // Bits most recently loaded completely into the chain (k = shift order).
    logic [L-1:0] prev_bits  = '0;
    bit           prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({bs_ready, ccff_head, chain_shift_en, busy, done, verify_ok, mismatch_cnt}), 32'd0);
    endtask

    // One pass: start, feed NWORD words with random stalls, collect head bits.
    // abort_after > 0 asserts pReset in the cycle of that shift.
    task automatic run_pass(input logic vmode, input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input int stall_pct, input bit mid_start,
                            input int abort_after);
        logic [W-1:0] words [NWORD];
        logic [L-1:0] exp_bits;
        logic [L-1:0] got;
        int widx, shifts, misses, cyc, done_cyc, late_ready, exp_mm;
        bit valid;
        words = '{w0, w1, w2};
        for (int k = 0; k < L; k++) exp_bits[k] = words[k / W][k % W];
        got = '0; widx = 0; shifts = 0; misses = 0; done_cyc = 0; late_ready = 0;

        start  = 1'b1;
        verify = vmode;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        cyc    = 1;
        check("start_response", 32'({busy, bs_ready, done, mismatch_cnt}), 32'({1'b1, 1'b1, 1'b0, 4'd0}));

        while (cyc < 300) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = 1'b0;
            if (chain_shift_en) begin
                if (shifts < L) got[shifts] = ccff_head;
                shifts++;
                if (mid_start && shifts == 5) begin
                    start  = 1'b1;
                    verify = ~vmode;
                end
            end
            if (abort_after > 0 && shifts == abort_after) begin
                pReset   = 1'b1;
                bs_valid = 1'b0;
                @(posedge prog_clk); #1;
                pReset   = 1'b0;
                start    = 1'b0;
                check_reset_outputs("abort_outputs");
                prev_valid = 1'b0;
                return;
            end
            if (bs_ready && widx >= NWORD) late_ready++;
            valid    = ($urandom_range(99) >= stall_pct);
            bs_valid = valid;
            bs_data  = (widx < NWORD) ? words[widx] : W'($urandom);
            if (bs_ready && !valid) misses++;
            if (bs_ready && valid && widx < NWORD) widx++;
            @(posedge prog_clk); #1;
            cyc++;
        end
        start    = 1'b0;
        bs_valid = 1'b0;

        exp_mm = vmode ? $countones(prev_bits ^ exp_bits) : 0;
        check("done_latency", 32'(done_cyc), 32'(2 + L + misses));
        check("shift_count", 32'(shifts), 32'(L));
        check("head_bits", 32'(got), 32'(exp_bits));
        check("ready_after_last_word", 32'(late_ready), 32'd0);
        check("busy_in_done", 32'({busy, bs_ready, chain_shift_en}), 32'd0);
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
        check("verify_ok", 32'(verify_ok), 32'(vmode && exp_mm == 0));
        prev_bits  = exp_bits;
        prev_valid = 1'b1;
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        bit vm;

        // Reset state
        repeat (2) @(posedge prog_clk);
        #1;
        check_reset_outputs("reset_outputs");
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        check_reset_outputs("idle_outputs");

        // Directed load, no stalls: head 0,1,0,1, 1,0,1,0, 1,1
        run_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, 1'b0, 0);
        repeat (3) @(posedge prog_clk);
        #1;
        check("done_held", 32'({done, busy}), 32'({1'b1, 1'b0}));

        // Verify with identical words, then with one flipped bit
        run_pass(1'b1, 4'hA, 4'h5, 4'h3, 0, 1'b0, 0);
        run_pass(1'b1, 4'hB, 4'h5, 4'h3, 0, 1'b0, 0);

        // Stalled load with random words
        run_pass(1'b0, W'($urandom), W'($urandom), W'($urandom), 40, 1'b0, 0);

        // Random passes; some with start pulsed mid-shift
        for (int p = 0; p < 8; p++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            c  = W'($urandom);
            vm = 1'($urandom_range(1));
            run_pass(vm, a, b, c, $urandom_range(50), (p % 2) == 1, 0);
            if (vm) run_pass(1'b1, a, b, c, $urandom_range(30), 1'b0, 0);
        end

        // Reset after 3 shifts, then a full pass and a verify of it
        run_pass(1'b0, 4'h6, 4'h9, 4'hC, 0, 1'b0, 3);
        @(posedge prog_clk); #1;
        check_reset_outputs("idle_after_abort");
        run_pass(1'b0, 4'h1, 4'hE, 4'h7, 20, 1'b0, 0);
        run_pass(1'b1, 4'h1, 4'hE, 4'h7, 20, 1'b0, 0);
        run_pass(1'b1, 4'h1, 4'hE, 4'h4, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
